// File: rtl/video_pkg.sv
// Shared timing constants (default 640x480@60 raster) and the sync-bundle type
// used by the optional alignment delay line.
package video_pkg;

  localparam int unsigned COORDSPC = 16;
  localparam int unsigned FCNT_W   = 16;

  localparam int unsigned H_RES  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;

  localparam int unsigned V_RES  = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;

  localparam int          H_STA   = -int'(H_FP + H_SYNC + H_BP);
  localparam int          V_STA   = -int'(V_FP + V_SYNC + V_BP);
  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // Sync/enable bundle carried through the colour-stage alignment line
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bus: coordinates, sync/enable flags, strobes and frame counter.
interface video_timing_if #(
  parameter int unsigned COORDSPC = 16
);

  logic signed [COORDSPC-1:0] sx;
  logic signed [COORDSPC-1:0] sy;
  logic                       hsync;
  logic                       vsync;
  logic                       video_enable;
  logic                       frame_start;
  logic                       line_start;
  logic [15:0]                frame_cnt;
  logic                       hsync_dly;
  logic                       vsync_dly;
  logic                       de_dly;

  modport master (
    output sx, sy, hsync, vsync, video_enable, frame_start, line_start,
           frame_cnt, hsync_dly, vsync_dly, de_dly
  );

  modport slave (
    input sx, sy, hsync, vsync, video_enable, frame_start, line_start,
          frame_cnt, hsync_dly, vsync_dly, de_dly
  );

endinterface

// File: rtl/video_sync_delay.sv
// DEPTH-stage delay line for hsync/vsync/de, reset to inactive levels.
// Compiled in only when VIDEO_TIMING_ALIGN_EN is defined.
`ifdef VIDEO_TIMING_ALIGN_EN
module video_sync_delay
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter bit          H_POL = 1'b0,
  parameter bit          V_POL = 1'b0
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  sync_t d_i,
  output sync_t q_o
);

  localparam sync_t IDLE = '{hsync: ~H_POL, vsync: ~V_POL, de: 1'b0};

  sync_t [DEPTH-1:0] line_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= {DEPTH{IDLE}};
    end else begin
      line_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign q_o = line_q[DEPTH-1];

endmodule
`endif

// File: rtl/video_timing.sv
// Raster timing generator: signed sx/sy counters with zero-skew registered flags.
// VIDEO_TIMING_ALIGN_EN inserts a PIPE_DLY-deep delay on the *_dly outputs.
module video_timing #(
  parameter int unsigned COORDSPC = video_pkg::COORDSPC,
  parameter int unsigned H_RES    = video_pkg::H_RES,
  parameter int unsigned H_FP     = video_pkg::H_FP,
  parameter int unsigned H_SYNC   = video_pkg::H_SYNC,
  parameter int unsigned H_BP     = video_pkg::H_BP,
  parameter int unsigned V_RES    = video_pkg::V_RES,
  parameter int unsigned V_FP     = video_pkg::V_FP,
  parameter int unsigned V_SYNC   = video_pkg::V_SYNC,
  parameter int unsigned V_BP     = video_pkg::V_BP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic           video_clk_pix,
  input  logic           video_rst_n,
  video_timing_if.master timing_o
);

  localparam int unsigned CW     = COORDSPC;
  localparam int unsigned FCNT_W = video_pkg::FCNT_W;

  localparam int H_STA_I = -int'(H_FP + H_SYNC + H_BP);
  localparam int V_STA_I = -int'(V_FP + V_SYNC + V_BP);

  localparam logic signed [CW-1:0] H_STA  = CW'(H_STA_I);
  localparam logic signed [CW-1:0] H_END  = CW'(int'(H_RES) - 1);
  localparam logic signed [CW-1:0] HS_BEG = CW'(H_STA_I + int'(H_FP));
  localparam logic signed [CW-1:0] HS_END = CW'(H_STA_I + int'(H_FP + H_SYNC) - 1);
  localparam logic signed [CW-1:0] V_STA  = CW'(V_STA_I);
  localparam logic signed [CW-1:0] V_END  = CW'(int'(V_RES) - 1);
  localparam logic signed [CW-1:0] VS_BEG = CW'(V_STA_I + int'(V_FP));
  localparam logic signed [CW-1:0] VS_END = CW'(V_STA_I + int'(V_FP + V_SYNC) - 1);

  localparam longint C_MIN = -(longint'(1) <<< (CW - 1));
  localparam longint C_MAX = (longint'(1) <<< (CW - 1)) - 1;

  // Refuse to build a raster whose signed extremes overflow the coordinate width
  if (longint'(H_STA_I) < C_MIN || longint'(V_STA_I) < C_MIN ||
      longint'(H_RES) - 1 > C_MAX || longint'(V_RES) - 1 > C_MAX) begin : g_bad_coordspc
    $error("video_timing: timing extremes do not fit in COORDSPC bits");
  end

  if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_pipe_dly
    $error("video_timing: PIPE_DLY must be in 1..8");
  end

  logic signed [CW-1:0] sx_q, sx_d;
  logic signed [CW-1:0] sy_q, sy_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 video_enable_q, video_enable_d;
  logic                 line_start_q, line_start_d;
  logic                 frame_start_q, frame_start_d;
  logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;

  // Flags decode the next-state counters so they land with the coordinates they describe
  always_comb begin
    sx_d = sx_q + CW'(1);
    sy_d = sy_q;
    if (sx_q == H_END) begin
      sx_d = H_STA;
      sy_d = (sy_q == V_END) ? V_STA : sy_q + CW'(1);
    end

    hsync_d        = (sx_d >= HS_BEG && sx_d <= HS_END) ? H_POL : ~H_POL;
    vsync_d        = (sy_d >= VS_BEG && sy_d <= VS_END) ? V_POL : ~V_POL;
    video_enable_d = !sx_d[CW-1] && !sy_d[CW-1];
    line_start_d   = (sx_d == H_STA);
    frame_start_d  = line_start_d && (sy_d == V_STA);
    frame_cnt_d    = frame_cnt_q + {{(FCNT_W-1){1'b0}}, frame_start_d};
  end

  // Reset parks the counters on the last pixel so the first edge opens a frame
  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      sx_q           <= H_END;
      sy_q           <= V_END;
      hsync_q        <= ~H_POL;
      vsync_q        <= ~V_POL;
      video_enable_q <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      sx_q           <= sx_d;
      sy_q           <= sy_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      video_enable_q <= video_enable_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign timing_o.sx           = sx_q;
  assign timing_o.sy           = sy_q;
  assign timing_o.hsync        = hsync_q;
  assign timing_o.vsync        = vsync_q;
  assign timing_o.video_enable = video_enable_q;
  assign timing_o.line_start   = line_start_q;
  assign timing_o.frame_start  = frame_start_q;
  assign timing_o.frame_cnt    = frame_cnt_q;

`ifdef VIDEO_TIMING_ALIGN_EN
  video_pkg::sync_t dly_in, dly_out;

  assign dly_in = '{hsync: hsync_q, vsync: vsync_q, de: video_enable_q};

  video_sync_delay #(
    .DEPTH (PIPE_DLY),
    .H_POL (H_POL),
    .V_POL (V_POL)
  ) u_sync_delay (
    .clk_i  (video_clk_pix),
    .rst_ni (video_rst_n),
    .d_i    (dly_in),
    .q_o    (dly_out)
  );

  assign timing_o.hsync_dly = dly_out.hsync;
  assign timing_o.vsync_dly = dly_out.vsync;
  assign timing_o.de_dly    = dly_out.de;
`else
  assign timing_o.hsync_dly = hsync_q;
  assign timing_o.vsync_dly = vsync_q;
  assign timing_o.de_dly    = video_enable_q;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing on a reduced raster: fixed-vector table, per-frame
// counting sequences and randomized resets checked against a raster model.
module tb_video_timing;

  localparam int CW     = 16;
  localparam int H_RES  = 16;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 3;
  localparam int H_BP   = 3;
  localparam int V_RES  = 6;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 2;
  localparam bit H_POL  = 1'b0;
  localparam bit V_POL  = 1'b1;
  localparam int P_DLY  = 2;

  localparam int HT    = H_RES + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_RES + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;
  localparam int H_STA = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA = -(V_FP + V_SYNC + V_BP);
`ifdef VIDEO_TIMING_ALIGN_EN
  localparam int DLY = P_DLY;
`else
  localparam int DLY = 0;
`endif

  typedef struct packed {
    logic signed [CW-1:0] sx;
    logic signed [CW-1:0] sy;
    logic                 hs;
    logic                 vs;
    logic                 de;
    logic                 ls;
    logic                 fs;
    logic [15:0]          fc;
  } core_t;

  typedef struct packed {
    core_t c;
    logic  hsd;
    logic  vsd;
    logic  ded;
  } obs_t;

  typedef struct {
    int    cyc;
    core_t c;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t_now    = -1;

  always #5 clk = ~clk;

  video_timing_if #(.COORDSPC(CW)) vif ();

  video_timing #(
    .COORDSPC (CW),
    .H_RES (H_RES), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_RES (V_RES), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .H_POL (H_POL), .V_POL (V_POL), .PIPE_DLY (P_DLY)
  ) dut (
    .video_clk_pix (clk),
    .video_rst_n   (rst_n),
    .timing_o      (vif)
  );

  function automatic core_t mk(int x, int y, bit hs, bit vs, bit de, bit ls, bit fs, int fc);
    core_t c;
    c.sx = CW'(x);
    c.sy = CW'(y);
    c.hs = hs;
    c.vs = vs;
    c.de = de;
    c.ls = ls;
    c.fs = fs;
    c.fc = 16'(fc);
    return c;
  endfunction

  // Raster position from cycle index t since release; t < 0 means held in reset
  function automatic core_t model(int t);
    int p, x, y;
    if (t < 0) return mk(H_RES - 1, V_RES - 1, !H_POL, !V_POL, 1'b0, 1'b0, 1'b0, 0);
    p = t % FRAME;
    x = H_STA + p % HT;
    y = V_STA + p / HT;
    return mk(x, y,
              (x >= H_STA + H_FP && x < H_STA + H_FP + H_SYNC) ? H_POL : !H_POL,
              (y >= V_STA + V_FP && y < V_STA + V_FP + V_SYNC) ? V_POL : !V_POL,
              x >= 0 && y >= 0, (p % HT) == 0, p == 0, (t / FRAME + 1) % 65536);
  endfunction

  function automatic obs_t expect_at(int t);
    obs_t  o;
    core_t d;
    o.c   = model(t);
    d     = model(t - DLY);
    o.hsd = d.hs;
    o.vsd = d.vs;
    o.ded = d.de;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.c.sx = vif.sx;
    o.c.sy = vif.sy;
    o.c.hs = vif.hsync;
    o.c.vs = vif.vsync;
    o.c.de = vif.video_enable;
    o.c.ls = vif.line_start;
    o.c.fs = vif.frame_start;
    o.c.fc = vif.frame_cnt;
    o.hsd  = vif.hsync_dly;
    o.vsd  = vif.vsync_dly;
    o.ded  = vif.de_dly;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("sx=%0d sy=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d dly(h,v,de)=%b%b%b",
                     o.c.sx, o.c.sy, o.c.hs, o.c.vs, o.c.de, o.c.ls, o.c.fs, o.c.fc,
                     o.hsd, o.vsd, o.ded);
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got {%s} want {%s}", name, t_now, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t_now++;
    check_obs("cycle", sample(), expect_at(t_now));
  endtask

  // Assert reset between edges, check it without a clock, hold, release on a negedge
  task automatic reset_seq(int hold);
    #2;
    rst_n = 1'b0;
    #1;
    check_obs("rst_async", sample(), expect_at(-1));
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_obs("rst_hold", sample(), expect_at(-1));
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    t_now = -1;
  endtask

  initial begin
    vec_t vecs[10];
    int   hs_cnt, first_hs, ls_cnt, ls_prev, ls_per, vs_cnt, de_cnt, fs_cnt, t_de, t_ded;

    vecs[0] = '{0,   mk(-8, -5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1)};
    vecs[1] = '{2,   mk(-6, -5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1)};
    vecs[2] = '{4,   mk(-4, -5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1)};
    vecs[3] = '{5,   mk(-3, -5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1)};
    vecs[4] = '{24,  mk(-8, -4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1)};
    vecs[5] = '{72,  mk(-8, -2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1)};
    vecs[6] = '{127, mk(-1,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1)};
    vecs[7] = '{128, mk( 0,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1)};
    vecs[8] = '{263, mk(15,  5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1)};
    vecs[9] = '{264, mk(-8, -5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2)};

    // Fixed raster points after the first release
    reset_seq(2);
    foreach (vecs[i]) begin
      while (t_now < vecs[i].cyc) step();
      n_checks++;
      if (sample().c !== vecs[i].c) begin
        n_fail++;
        $display("FAIL vec%0d t=%0d got {%s}", i, t_now, fmt(sample()));
      end
    end

    // One full frame of counting from a fresh release
    reset_seq(1);
    hs_cnt = 0; first_hs = 9999; ls_cnt = 0; ls_prev = -1; ls_per = 0;
    vs_cnt = 0; de_cnt = 0; fs_cnt = 0; t_de = -1; t_ded = -1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (i < HT && vif.hsync == H_POL) begin
        hs_cnt++;
        if (first_hs == 9999) first_hs = int'(vif.sx);
      end
      if (vif.line_start) begin
        if (ls_prev >= 0 && ls_per == 0) ls_per = t_now - ls_prev;
        ls_prev = t_now;
        ls_cnt++;
      end
      if (vif.vsync == V_POL) vs_cnt++;
      if (vif.video_enable) de_cnt++;
      if (vif.frame_start) fs_cnt++;
      if (vif.video_enable && t_de < 0) t_de = t_now;
      if (vif.de_dly && t_ded < 0) t_ded = t_now;
    end
    check_int("hsync_len", hs_cnt, H_SYNC);
    check_int("hsync_first_sx", first_hs, H_STA + H_FP);
    check_int("line_period", ls_per, HT);
    check_int("lines_per_frame", ls_cnt, VT);
    check_int("vsync_len", vs_cnt, V_SYNC * HT);
    check_int("de_count", de_cnt, H_RES * V_RES);
    check_int("fs_per_frame", fs_cnt, 1);
    check_int("de_dly_lag", t_ded - t_de, DLY);
    step();
    check_int("next_frame_start", int'(vif.frame_start), 1);
    check_int("frame_cnt_2", int'(vif.frame_cnt), 2);
    repeat (3 * FRAME) step();

    // Randomized mid-frame resets and run lengths
    repeat (8) begin
      reset_seq(int'($urandom_range(0, 3)));
      repeat (int'($urandom_range(20, 700))) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
